axi_lite_io_slave: RTL
======================

Name: axi_lite_io_slave

Overview:
- AXI4-Lite responder (slave) that terminates IO transactions arriving from an AXI-Lite master and converts them to the single-cycle IO bus used by on-chip peripherals (UART, timers, GPIO).
- Serializes reads and writes: one outstanding transaction at a time, fair read/write arbitration.
- Out-of-window addresses are decoded locally and answered with DECERR.

Parameters:
- C_S_AXI_ADDR_WIDTH, 32, AXI address width.
- C_S_AXI_DATA_WIDTH, 32, AXI/IO data width. Only 32 is supported.
- BASE_ADDR, 32'hFFFF0000, base of the decoded IO window.
- WINDOW_BITS, 16, window size is 2^WINDOW_BITS bytes. An address hits when addr[ADDR_WIDTH-1:WINDOW_BITS] == BASE_ADDR[ADDR_WIDTH-1:WINDOW_BITS].

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_axi_awaddr  in  ADDR_WIDTH  write address
- s_axi_awprot  in  3  ignored
- s_axi_awvalid  in  1 / s_axi_awready  out  1
- s_axi_wdata  in  DATA_WIDTH / s_axi_wstrb  in  DATA_WIDTH/8
- s_axi_wvalid  in  1 / s_axi_wready  out  1
- s_axi_bresp  out  2 / s_axi_bvalid  out  1 / s_axi_bready  in  1
- s_axi_araddr  in  ADDR_WIDTH / s_axi_arprot  in  3 (ignored)
- s_axi_arvalid  in  1 / s_axi_arready  out  1
- s_axi_rdata  out  DATA_WIDTH / s_axi_rresp  out  2
- s_axi_rvalid  out  1 / s_axi_rready  in  1
- io_write_en  out  1  one-cycle write strobe
- io_read_en  out  1  one-cycle read strobe
- io_address  out  ADDR_WIDTH  captured address (full, unmasked)
- io_write_data  out  DATA_WIDTH  captured wdata
- io_write_mask  out  DATA_WIDTH/8  captured wstrb
- io_read_data  in  DATA_WIDTH  valid exactly 1 cycle after io_read_en

Behaviour:
- Reset values:
  - all AXI valid/ready outputs = 0
  - bresp = rresp = 0, rdata = 0
  - io_write_en = io_read_en = 0; io_address, io_write_data, io_write_mask = 0
  - state = IDLE, priority flag = write-first
- Reset mid-transaction abandons the transaction. No io strobe or AXI response is issued for it.
- States:
  - IDLE
  - WAIT_W: have AW, need W
  - WAIT_AW: have W, need AW
  - W_ISSUE
  - W_RESP
  - R_ISSUE
  - R_WAIT
  - R_RESP
- Readies are combinational from state plus valids (AXI permits ready depending on valid) and are forced to 0 while reset is high.
- IDLE arbitration:
  - write_req = awvalid | wvalid; read_req = arvalid.
  - If both are requested, the priority flag chooses. The flag toggles to the other side after every completed response.
  - Write selected: awready = awvalid, wready = wvalid.
    - Both accepted in the same cycle -> W_ISSUE.
    - Only AW accepted -> WAIT_W.
    - Only W accepted -> WAIT_AW.
  - Read selected: arready = 1 -> R_ISSUE.
- WAIT_W: wready = 1; W handshake -> W_ISSUE. WAIT_AW: awready = 1; AW handshake -> W_ISSUE. arready = 0 in both states.
- Captured address/data/strobe registers load on their handshake and drive io_address, io_write_data and io_write_mask.
- W_ISSUE:
  - io_write_en = hit (address in window).
  - Latch bresp = hit ? 2'b00 : 2'b11.
  - -> W_RESP.
- W_RESP: bvalid = 1, held until bready. On handshake -> IDLE and toggle priority.
- R_ISSUE: io_read_en = hit -> R_WAIT.
- R_WAIT:
  - rdata <= hit ? io_read_data : 0.
  - rresp <= hit ? OKAY : DECERR.
  - -> R_RESP.
- R_RESP: rvalid = 1; rdata and rresp are held stable until rready. On handshake -> IDLE and toggle priority.
- Latency:
  - AW+W accepted at edge N -> io_write_en high in cycle N+1 -> bvalid high in cycle N+2.
  - AR accepted at edge N -> io_read_en in cycle N+1 -> rvalid in cycle N+3.
- io_write_en and io_read_en are never both high. Each is high for at most 1 cycle per transaction.
- Never more than one outstanding transaction. While any state other than IDLE/WAIT_* is active, all readies are 0.
- wstrb = 0 still issues io_write_en with io_write_mask = 0. The peripheral honours the mask.
- bready or rready held low indefinitely stalls the block. No timeout.

Decomposition:
- Shared package (defines):
  - AXI response constants AXI_RESP_OKAY = 2'b00, AXI_RESP_SLVERR = 2'b10, AXI_RESP_DECERR = 2'b11
  - the state enum axi_slave_state_t (3 bits)
- No sub-module. A single always_ff holds state and capture registers; a single always_comb produces readies and strobes.

Test Plan:
- Write 0xFFFF0004 / 0xDEADBEEF, wstrb 4'hF, AW and W in the same cycle -> io_write_en pulses 1 cycle with io_address = 0xFFFF0004, io_write_data = 0xDEADBEEF; then bvalid with bresp = 0.
- Read 0xFFFF0008, peripheral returns 0x12345678 one cycle after io_read_en -> rvalid with rdata = 0x12345678, rresp = 0; rvalid holds while rready is low for 5 cycles.
- W presented 3 cycles before AW -> WAIT_AW entered; a single io_write_en after AW; AR asserted meanwhile stays unaccepted until bvalid/bready completes.
- Read 0x00001000 (out of window) -> no io_read_en; rresp = 2'b11, rdata = 0. Write to the same address -> no io_write_en; bresp = 2'b11.
- AW/W and AR valid continuously for 4 transactions -> alternating order write, read, write, read, starting with write after reset.
- Reset asserted in R_WAIT -> no rvalid; all outputs 0 next cycle; a subsequent read completes normally.

Source files
------------

// File: rtl/axi_lite_io_slave_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_io_slave_pkg
// Shared definitions for the AXI4-Lite to IO-bus bridge:
//   - AXI response codes
//   - controller state encoding (3 bits)
// ---------------------------------------------------------------------------
package axi_lite_io_slave_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_W  = 3'd1,   // address taken, waiting for write data
        ST_WAIT_AW = 3'd2,   // write data taken, waiting for address
        ST_W_ISSUE = 3'd3,
        ST_W_RESP  = 3'd4,
        ST_R_ISSUE = 3'd5,
        ST_R_WAIT  = 3'd6,
        ST_R_RESP  = 3'd7
    } axi_slave_state_t;

endpackage

// File: rtl/axi_lite_io_slave_if.sv
// ---------------------------------------------------------------------------
// axi_lite_io_slave_if
// AXI4-Lite bundle between a bus master and the IO bridge.
//   master modport : drives AW/W/AR channels and B/R readies
//   slave  modport : drives AW/W/AR readies and the B/R channels
// ---------------------------------------------------------------------------
interface axi_lite_io_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_io_slave.sv
// ---------------------------------------------------------------------------
// axi_lite_io_slave
// Terminates AXI4-Lite transactions and replays them, one at a time, on the
// single-cycle on-chip IO bus. Reads and writes alternate priority after each
// completed response. Addresses outside the IO window get DECERR and never
// reach the IO bus.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   s_axi          : AXI4-Lite slave side (interface, slave modport)
//   io_write_en    : one-cycle write strobe
//   io_read_en     : one-cycle read strobe
//   io_address     : captured AXI address (full width)
//   io_write_data  : captured write data
//   io_write_mask  : captured write strobes
//   io_read_data   : peripheral read data, valid one cycle after io_read_en
// ---------------------------------------------------------------------------
module axi_lite_io_slave
    import axi_lite_io_slave_pkg::*;
#(
    parameter int                            C_S_AXI_ADDR_WIDTH = 32,
    parameter int                            C_S_AXI_DATA_WIDTH = 32,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = 32'hFFFF_0000,
    parameter int                            WINDOW_BITS        = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    axi_lite_io_slave_if.slave                s_axi,
    output logic                              io_write_en,
    output logic                              io_read_en,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]     io_address,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     io_write_data,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]   io_write_mask,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     io_read_data
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [AW-WINDOW_BITS-1:0] BASE_HI = BASE_ADDR[AW-1:WINDOW_BITS];

    axi_slave_state_t r_state;
    axi_slave_state_t w_next_state;
    logic             r_prio_read;      // 0: write wins a tie, 1: read wins
    logic [AW-1:0]    r_addr;           // shared by AW and AR, only one is ever live
    logic [DW-1:0]    r_wdata;
    logic [SW-1:0]    r_wstrb;
    logic [1:0]       r_bresp;
    logic [1:0]       r_rresp;
    logic [DW-1:0]    r_rdata;

    logic w_awready, w_wready, w_arready, w_bvalid, w_rvalid;
    logic w_io_write_en, w_io_read_en;
    logic w_write_req, w_read_req, w_pick_write;
    logic w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_r_hs;
    logic w_hit;
    logic w_unused_prot;

    assign w_hit        = (r_addr[AW-1:WINDOW_BITS] == BASE_HI);
    assign w_write_req  = s_axi.awvalid | s_axi.wvalid;
    assign w_read_req   = s_axi.arvalid;
    assign w_pick_write = w_write_req & (~w_read_req | ~r_prio_read);
    assign w_unused_prot = ^{s_axi.awprot, s_axi.arprot};

    assign w_aw_hs = s_axi.awvalid & w_awready;
    assign w_w_hs  = s_axi.wvalid  & w_wready;
    assign w_ar_hs = s_axi.arvalid & w_arready;
    assign w_b_hs  = w_bvalid & s_axi.bready;
    assign w_r_hs  = w_rvalid & s_axi.rready;

    // Next-state decode plus readies, response valids and IO strobes.
    always_comb begin
        w_next_state  = r_state;
        w_awready     = 1'b0;
        w_wready      = 1'b0;
        w_arready     = 1'b0;
        w_bvalid      = 1'b0;
        w_rvalid      = 1'b0;
        w_io_write_en = 1'b0;
        w_io_read_en  = 1'b0;
        if (reset) begin
            // Everything stays quiet so an abandoned transaction emits nothing.
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_write) begin
                        w_awready = s_axi.awvalid;
                        w_wready  = s_axi.wvalid;
                        if (s_axi.awvalid && s_axi.wvalid) begin
                            w_next_state = ST_W_ISSUE;
                        end else if (s_axi.awvalid) begin
                            w_next_state = ST_WAIT_W;
                        end else begin
                            w_next_state = ST_WAIT_AW;
                        end
                    end else if (w_read_req) begin
                        w_arready    = 1'b1;
                        w_next_state = ST_R_ISSUE;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
                ST_WAIT_W: begin
                    w_wready = 1'b1;
                    if (s_axi.wvalid) begin
                        w_next_state = ST_W_ISSUE;
                    end else begin
                        w_next_state = ST_WAIT_W;
                    end
                end
                ST_WAIT_AW: begin
                    w_awready = 1'b1;
                    if (s_axi.awvalid) begin
                        w_next_state = ST_W_ISSUE;
                    end else begin
                        w_next_state = ST_WAIT_AW;
                    end
                end
                ST_W_ISSUE: begin
                    w_io_write_en = w_hit;
                    w_next_state  = ST_W_RESP;
                end
                ST_W_RESP: begin
                    w_bvalid = 1'b1;
                    if (s_axi.bready) begin
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_state = ST_W_RESP;
                    end
                end
                ST_R_ISSUE: begin
                    w_io_read_en = w_hit;
                    w_next_state = ST_R_WAIT;
                end
                ST_R_WAIT: begin
                    w_next_state = ST_R_RESP;
                end
                ST_R_RESP: begin
                    w_rvalid = 1'b1;
                    if (s_axi.rready) begin
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_state = ST_R_RESP;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // State, arbitration flag, captured request and latched response.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_prio_read <= 1'b0;
            r_addr      <= {AW{1'b0}};
            r_wdata     <= {DW{1'b0}};
            r_wstrb     <= {SW{1'b0}};
            r_bresp     <= AXI_RESP_OKAY;
            r_rresp     <= AXI_RESP_OKAY;
            r_rdata     <= {DW{1'b0}};
        end else begin
            r_state <= w_next_state;
            // AW and AR are never accepted in the same cycle.
            if (w_aw_hs) begin
                r_addr <= s_axi.awaddr;
            end else if (w_ar_hs) begin
                r_addr <= s_axi.araddr;
            end
            if (w_w_hs) begin
                r_wdata <= s_axi.wdata;
                r_wstrb <= s_axi.wstrb;
            end
            if (r_state == ST_W_ISSUE) begin
                r_bresp <= w_hit ? AXI_RESP_OKAY : AXI_RESP_DECERR;
            end
            // io_read_data is valid in the cycle after io_read_en.
            if (r_state == ST_R_WAIT) begin
                r_rdata <= w_hit ? io_read_data : {DW{1'b0}};
                r_rresp <= w_hit ? AXI_RESP_OKAY : AXI_RESP_DECERR;
            end
            if (w_b_hs || w_r_hs) begin
                r_prio_read <= ~r_prio_read;
            end
        end
    end

    assign s_axi.awready = w_awready;
    assign s_axi.wready  = w_wready;
    assign s_axi.arready = w_arready;
    assign s_axi.bvalid  = w_bvalid;
    assign s_axi.bresp   = r_bresp;
    assign s_axi.rvalid  = w_rvalid;
    assign s_axi.rresp   = r_rresp;
    assign s_axi.rdata   = r_rdata;

    assign io_write_en   = w_io_write_en;
    assign io_read_en    = w_io_read_en;
    assign io_address    = r_addr;
    assign io_write_data = r_wdata;
    assign io_write_mask = r_wstrb;

endmodule
